slice_sum_reconstructor: RTL and testbench
==========================================

# slice_sum_reconstructor

Sequential consumer of the 8-bit sliced carry-lookahead chain: accepts operand slices together with the four group carries produced for each slice. Reconstructs the sum bits, feeds the chained carry back to the carry generator, and assembles a full-width result. Every supplied group carry is independently recomputed, and any mismatch raises a sticky fault flag for fault-injection detection on the carry path. Sits directly downstream of the sliced carry generator in the protected adder datapath.

## Interface
- NSLICES, 4, number of 8-bit slices per operation; result width is 8*NSLICES
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  slice presented
- in_ready  out  1  slice can be accepted
- in_a  in  8  operand A slice, least-significant slice first
- in_b  in  8  operand B slice
- in_cin  in  1  operation carry-in; sampled only on the first slice
- c_grp  in  4  group carries for the current slice; c_grp[k] = carry out of bit pair k (bits 2k+1:2k)
- c_chain  out  1  carry-in for the carry generator on the current slice
- out_valid  out  1  result available
- out_ready  in  1  result consumed
- out_sum  out  8*NSLICES  sum
- out_cout  out  1  final carry out (= c_grp[3] of last slice)
- out_fault  out  1  any supplied carry disagreed with recomputation during this operation

## Operation
- States: IDLE (no slice yet), ACCUM (1..NSLICES-1 slices taken), DONE (result held).
- Accept occurs on in_valid && in_ready. in_ready = !rst && state != DONE.
- Slice index idx counts 0..NSLICES-1. c_chain = in_cin when idx==0, else carry_reg.
- Per accepted slice:
  - carry into pair 0 is c_chain; carry into pair k>0 is c_grp[k-1].
  - Within each pair: s0 = a0^b0^cin_k; internal carry = maj(a0,b0,cin_k); s1 = a1^b1^internal.
  - Sum bits are written into out_sum[8*idx+7:8*idx]. Sum uses the supplied carries, not the recomputed ones.
  - The recomputed pair carry-out is compared with c_grp[k]. Any mismatch sets fault_acc, which is sticky per operation.
  - carry_reg <= c_grp[3].
- Transitions:
  - IDLE→ACCUM on the first accept, or →DONE if NSLICES==1.
  - ACCUM→DONE on the accept with idx==NSLICES-1.
  - DONE→IDLE on out_valid && out_ready.
  - Leaving DONE clears idx, carry_reg and fault_acc. out_sum is retained until overwritten.
- Reset values: state IDLE, idx 0, carry_reg 0, out_valid 0, out_sum 0, out_cout 0, out_fault 0.
- Reset mid-operation discards partial slices. The next accepted slice is treated as idx 0.

## Timing
- out_valid rises the cycle after the last slice is accepted. out_sum, out_cout and out_fault are registered and stable while out_valid && !out_ready.
- Minimum period is NSLICES+1 cycles per operation. No new slice is accepted in the cycle the result is consumed; in_ready rises the following cycle.
- c_chain is combinational from state/in_cin. Carry-gen path: in_a/in_b/c_chain → carry gen → c_grp, all within one cycle.
- in_valid low between slices inserts idle cycles. State and partial sum are held.

## Structure
- Package slice_adder_pkg holds: SLICE_W=8, PAIRS=4, the state enum {IDLE, ACCUM, DONE}, and a function for pair majority.
- Sub-module pair_sum_check: inputs a[1:0], b[1:0], cin; outputs s[1:0] and ref_cout. The top level instantiates four per slice.

## Test plan
- NSLICES=4, a=0xFFFFFFFF, b=0x00000001, cin=0, correct c_grp (slice0 4'hF, slices1-3 4'hF) -> out_sum=0x00000000, out_cout=1, out_fault=0, out_valid 1 cycle after 4th accept.
- a=0x12345678, b=0x9ABCDEF0, cin=1, correct carries -> out_sum=0xACF13569, out_cout=0, out_fault=0; c_chain on slice0 = 1.
- Same as first case but c_grp slice0 forced to 4'h7 -> out_fault=1; next operation with correct carries -> out_fault=0, which proves the flag is cleared per operation.
- a=0x7FFFFFFF, b=0x80000000, cin=1, out_ready low 3 cycles -> out_valid and out_sum=0x00000000, out_cout=1 held stable, in_ready=0 throughout; in_ready=1 the cycle after the handshake.
- Accept 2 slices, assert rst 1 cycle, then run 0x00000001+0x00000001 -> out_sum=0x00000002, out_cout=0, no stale carry or fault.
- in_valid gapped (1 slice every 3 cycles) with random operands -> result matches a+b+cin, out_fault=0.

Source files
------------

// File: rtl/slice_adder_pkg.sv
// Shared constants, FSM state encoding and carry helpers for the sliced
// adder reconstruction datapath.
package slice_adder_pkg;

    localparam int SLICE_W = 8;
    localparam int PAIRS   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Majority of three: the carry out of a single full-adder bit.
    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/slice_sum_reconstructor_if.sv
// Slice input / result output bundle between the carry generator, the
// reconstructor and the result consumer.
interface slice_sum_reconstructor_if #(
    parameter int NSLICES = 4
);
    // Both channels use strict valid/ready: a transfer happens on the rising
    // edge where valid && ready; a source holds valid and payload until then.
    logic                   in_valid;
    logic                   in_ready;
    logic [7:0]             in_a;
    logic [7:0]             in_b;
    logic                   in_cin;
    logic [3:0]             c_grp;
    logic                   c_chain;
    logic                   out_valid;
    logic                   out_ready;
    logic [8*NSLICES-1:0]   out_sum;
    logic                   out_cout;
    logic                   out_fault;

    modport slave (
        input  in_valid, in_a, in_b, in_cin, c_grp, out_ready,
        output in_ready, c_chain, out_valid, out_sum, out_cout, out_fault
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, c_grp, out_ready,
        input  in_ready, c_chain, out_valid, out_sum, out_cout, out_fault
    );

endinterface

// File: rtl/pair_sum_check.sv
// Two-bit sum reconstruction from a supplied carry-in, plus an independent
// recomputation of the pair carry-out for checking the supplied carries.
module pair_sum_check
    import slice_adder_pkg::*;
(
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       cin,
    output logic [1:0] s,
    output logic       ref_cout
);

    logic c_mid;

    assign s[0]     = a[0] ^ b[0] ^ cin;
    assign c_mid    = maj(a[0], b[0], cin);
    assign s[1]     = a[1] ^ b[1] ^ c_mid;
    assign ref_cout = maj(a[1], b[1], c_mid);

endmodule

// File: rtl/slice_sum_reconstructor.sv
// Accepts operand slices with their group carries, rebuilds the full-width
// sum, chains the carry back to the generator and flags carry disagreements.
module slice_sum_reconstructor
    import slice_adder_pkg::*;
#(
    parameter int NSLICES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    slice_sum_reconstructor_if.slave bus,
    output state_t                   fsm_state
);

    localparam int               IDX_W    = (NSLICES > 1) ? $clog2(NSLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICES - 1);

    state_t                   state;
    logic [IDX_W-1:0]         idx;
    logic                     carry_reg;
    logic                     fault_acc;
    logic [SLICE_W*NSLICES-1:0] sum_q;
    logic                     valid_q;
    logic                     cout_q;
    logic                     fault_q;

    logic [PAIRS-1:0]         pair_cin;
    logic [PAIRS-1:0]         ref_c;
    logic [SLICE_W-1:0]       slice_sum;
    logic                     accept;
    logic                     mismatch;

    assign bus.in_ready  = !rst && (state != DONE);
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.c_chain   = (idx == '0) ? bus.in_cin : carry_reg;

    // Sum bits are built from the supplied carries so a corrupted carry shows
    // up in the result exactly as the downstream datapath would see it.
    assign pair_cin      = {bus.c_grp[PAIRS-2:0], bus.c_chain};
    assign mismatch      = |(ref_c ^ bus.c_grp);

    assign bus.out_valid = valid_q;
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_q;
    assign bus.out_fault = fault_q;
    assign fsm_state     = state;

    for (genvar k = 0; k < PAIRS; k++) begin : g_pair
        pair_sum_check u_pair (
            .a        (bus.in_a[2*k+1:2*k]),
            .b        (bus.in_b[2*k+1:2*k]),
            .cin      (pair_cin[k]),
            .s        (slice_sum[2*k+1:2*k]),
            .ref_cout (ref_c[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            carry_reg <= 1'b0;
            fault_acc <= 1'b0;
            sum_q     <= '0;
            valid_q   <= 1'b0;
            cout_q    <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        for (int i = 0; i < NSLICES; i++) begin
                            if (idx == IDX_W'(i)) begin
                                sum_q[i*SLICE_W +: SLICE_W] <= slice_sum;
                            end
                        end
                        carry_reg <= bus.c_grp[PAIRS-1];
                        fault_acc <= fault_acc | mismatch;
                        if (idx == LAST_IDX) begin
                            state   <= DONE;
                            valid_q <= 1'b1;
                            cout_q  <= bus.c_grp[PAIRS-1];
                            fault_q <= fault_acc | mismatch;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= ACCUM;
                        end
                    end
                end
                DONE: begin
                    // Result held until consumed; the sum stays visible
                    // afterwards until the next operation overwrites it.
                    if (bus.out_ready) begin
                        state     <= IDLE;
                        valid_q   <= 1'b0;
                        idx       <= '0;
                        carry_reg <= 1'b0;
                        fault_acc <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_slice_sum_reconstructor.sv
// Bench for slice_sum_reconstructor: a carry-generator model drives c_grp from
// slice operands, results are checked against table constants and a reference.
module tb_slice_sum_reconstructor;
    import slice_adder_pkg::*;

    localparam int NS = 4;

    logic   clk;
    logic   rst;
    state_t fsm_state;

    slice_sum_reconstructor_if #(.NSLICES(NS)) bus ();

    slice_sum_reconstructor #(.NSLICES(NS)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Carry out of each bit pair as a real carry generator would produce it:
    // the carry out of the low (2k+2) bits of a+b+cin.
    function automatic logic [3:0] true_carries(input logic [7:0] a, input logic [7:0] b,
                                                input logic cin);
        logic [3:0] c;
        int lim;
        int tot;
        for (int k = 0; k < 4; k++) begin
            lim  = 1 << (2 * k + 2);
            tot  = (int'(a) % lim) + (int'(b) % lim) + int'(cin);
            c[k] = (tot >= lim);
        end
        return c;
    endfunction

    // Result of one operation when slice fslice has its carries XORed with fmask.
    function automatic void model_op(input logic [31:0] a, input logic [31:0] b,
                                     input logic cin, input int fslice,
                                     input logic [3:0] fmask, output logic [31:0] sum,
                                     output logic cout, output logic fault);
        logic       chain;
        logic       ck;
        logic [3:0] sup;
        int         t;
        chain = cin;
        fault = 1'b0;
        sum   = '0;
        for (int s = 0; s < NS; s++) begin
            sup = true_carries(a[8*s +: 8], b[8*s +: 8], chain) ^ ((s == fslice) ? fmask : 4'h0);
            for (int k = 0; k < 4; k++) begin
                ck = (k == 0) ? chain : sup[k-1];
                t  = int'(a[8*s+2*k +: 2]) + int'(b[8*s+2*k +: 2]) + int'(ck);
                sum[8*s+2*k +: 2] = t[1:0];
                if ((t >= 4) != sup[k]) fault = 1'b1;
            end
            chain = sup[3];
        end
        cout = chain;
    endfunction

    // ---------------- driver ----------------
    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.c_grp     = '0;
        bus.out_ready = 1'b0;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                          input int fslice, input logic [3:0] fmask, input int gap,
                          input int hold, input logic [31:0] exp_sum, input logic exp_cout,
                          input logic exp_fault, input string tag);
        logic        chain;
        logic [3:0]  sup;
        logic [31:0] exp;
        int          waited;
        exp_q.push_back(exp_sum);
        chain = cin;
        for (int s = 0; s < NS; s++) begin
            waited = 0;
            while (bus.in_ready !== 1'b1 && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            chk({tag, "_in_ready_slice"}, bus.in_ready, 1'b1);
            bus.in_valid = 1'b1;
            bus.in_a     = a[8*s +: 8];
            bus.in_b     = b[8*s +: 8];
            bus.in_cin   = (s == 0) ? cin : ~cin;
            sup          = true_carries(a[8*s +: 8], b[8*s +: 8], chain)
                           ^ ((s == fslice) ? fmask : 4'h0);
            bus.c_grp    = sup;
            #1;
            chk($sformatf("%s_c_chain%0d", tag, s), bus.c_chain, chain);
            if (s == NS - 1) chk({tag, "_valid_early"}, bus.out_valid, 1'b0);
            @(negedge clk);
            chain        = sup[3];
            bus.in_valid = 1'b0;
            if (s < NS - 1) repeat (gap) @(negedge clk);
        end
        chk({tag, "_out_valid"}, bus.out_valid, 1'b1);
        chk({tag, "_in_ready_done"}, bus.in_ready, 1'b0);
        exp = exp_q.pop_front();
        chk({tag, "_out_sum"}, bus.out_sum, exp);
        chk({tag, "_out_cout"}, bus.out_cout, exp_cout);
        chk({tag, "_out_fault"}, bus.out_fault, exp_fault);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, bus.out_valid, 1'b1);
            chk({tag, "_hold_sum"}, bus.out_sum, exp);
            chk({tag, "_hold_cout"}, bus.out_cout, exp_cout);
            chk({tag, "_hold_in_ready"}, bus.in_ready, 1'b0);
        end
        bus.out_ready = 1'b1;
        #1;
        chk({tag, "_in_ready_consume"}, bus.in_ready, 1'b0);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, "_valid_after"}, bus.out_valid, 1'b0);
        chk({tag, "_in_ready_after"}, bus.in_ready, 1'b1);
    endtask

    // ---------------- test table ----------------
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        int          fslice;
        logic [3:0]  fmask;
        int          hold;
        logic [31:0] sum;
        logic        cout;
        logic        fault;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [31:0] ra, rb, msum;
        logic        rc, mcout, mfault;
        logic [32:0] wide;
        int          fs;
        logic [3:0]  fm;

        vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, -1, 4'h0, 0, 32'h00000000, 1'b1, 1'b0};
        vecs[1] = '{32'h12345678, 32'h9ABCDEF0, 1'b1, -1, 4'h0, 0, 32'hACF13569, 1'b0, 1'b0};
        vecs[2] = '{32'hFFFFFFFF, 32'h00000001, 1'b0,  0, 4'h8, 0, 32'hFFFFFF00, 1'b0, 1'b1};
        vecs[3] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, -1, 4'h0, 0, 32'h00000000, 1'b1, 1'b0};
        vecs[4] = '{32'h7FFFFFFF, 32'h80000000, 1'b1, -1, 4'h0, 3, 32'h00000000, 1'b1, 1'b0};

        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("in_ready_in_reset", bus.in_ready, 1'b0);
        rst = 1'b0;
        #1;
        chk("reset_state", fsm_state, IDLE);
        chk("reset_out_valid", bus.out_valid, 1'b0);
        chk("reset_out_sum", bus.out_sum, 32'h0);
        chk("reset_out_cout", bus.out_cout, 1'b0);
        chk("reset_out_fault", bus.out_fault, 1'b0);
        chk("reset_in_ready", bus.in_ready, 1'b1);
        bus.in_cin = 1'b1;
        #1;
        chk("reset_c_chain_cin1", bus.c_chain, 1'b1);
        bus.in_cin = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].fslice, vecs[i].fmask, 0,
                   vecs[i].hold, vecs[i].sum, vecs[i].cout, vecs[i].fault, $sformatf("vec%0d", i));
        end

        // Reset in the middle of an operation: two slices that leave a carry behind.
        for (int s = 0; s < 2; s++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = 8'hFF;
            bus.in_b     = 8'hFF;
            bus.in_cin   = 1'b1;
            bus.c_grp    = 4'hF;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        chk("mid_state_accum", fsm_state, ACCUM);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.in_cin = 1'b0;
        #1;
        chk("mid_reset_state", fsm_state, IDLE);
        chk("mid_reset_c_chain", bus.c_chain, 1'b0);
        @(negedge clk);
        run_op(32'h00000001, 32'h00000001, 1'b0, -1, 4'h0, 0, 0, 32'h00000002, 1'b0, 1'b0, "post_rst");

        // Gapped slices: one every three cycles.
        for (int i = 0; i < 4; i++) begin
            ra   = $urandom;
            rb   = $urandom;
            rc   = 1'($urandom_range(0, 1));
            wide = {1'b0, ra} + {1'b0, rb} + {32'h0, rc};
            run_op(ra, rb, rc, -1, 4'h0, 2, 0, wide[31:0], wide[32], 1'b0, $sformatf("gap%0d", i));
        end

        // Random operations with occasional carry corruption.
        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                fs = $urandom_range(0, NS - 1);
                fm = 4'($urandom_range(1, 15));
            end else begin
                fs = -1;
                fm = 4'h0;
            end
            if (fs < 0) begin
                wide   = {1'b0, ra} + {1'b0, rb} + {32'h0, rc};
                msum   = wide[31:0];
                mcout  = wide[32];
                mfault = 1'b0;
            end else begin
                model_op(ra, rb, rc, fs, fm, msum, mcout, mfault);
            end
            run_op(ra, rb, rc, fs, fm, $urandom_range(0, 1), $urandom_range(0, 2),
                   msum, mcout, mfault, $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
